// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the chunked carry look-ahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK_W-bit carry look-ahead slice: PG generation plus
// fully flattened carries (every c[i+1] is a sum of products of g, p and ci).
module cla_slice #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  logic [CHUNK_W-1:0] g_s;
  logic [CHUNK_W-1:0] p_s;
  logic [CHUNK_W:0]   c_s;

  assign g_s = x & y;
  assign p_s = x ^ y;

  // Look-ahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  always_comb begin
    logic term_s;
    logic acc_s;
    c_s = {(CHUNK_W+1){1'b0}};
    c_s[0] = ci;
    for (int i = 0; i < CHUNK_W; i++) begin
      term_s = ci;
      for (int k = 0; k <= i; k++) begin
        term_s = term_s & p_s[k];
      end
      acc_s = term_s;
      for (int j = 0; j <= i; j++) begin
        term_s = g_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term_s = term_s & p_s[k];
        end
        acc_s = acc_s | term_s;
      end
      c_s[i+1] = acc_s;
    end
  end

  assign s  = p_s ^ c_s[CHUNK_W-1:0];
  assign co = c_s[CHUNK_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: one CLA slice walked over NUM_CHUNKS chunks with a
// registered inter-chunk carry. Optional macro SUB_EN adds a 'sub' port (a-b).
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 4,
  localparam int TOTAL_W   = CHUNK_W * NUM_CHUNKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] a,
  input  logic [TOTAL_W-1:0] b,
  input  logic               cIn,
`ifdef SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] sum,
  output logic               cOut
);

  localparam int IDX_W = idx_width(NUM_CHUNKS);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               in_ready_nxt_s;
  logic               out_valid_nxt_s;
  logic [TOTAL_W-1:0] a_r;
  logic [TOTAL_W-1:0] b_r;
  logic [TOTAL_W-1:0] sum_r;
  logic               carry_r;
  logic               cout_r;
  logic [IDX_W-1:0]   idx_r;
  logic               last_s;
  logic               accept_s;
  logic [CHUNK_W-1:0] x_s;
  logic [CHUNK_W-1:0] y_s;
  logic [CHUNK_W-1:0] slice_sum_s;
  logic               slice_co_s;

  assign accept_s = in_valid && in_ready_r;
  assign last_s   = (idx_r == IDX_W'(NUM_CHUNKS - 1));
  assign x_s      = a_r[idx_r*CHUNK_W +: CHUNK_W];
  assign y_s      = b_r[idx_r*CHUNK_W +: CHUNK_W];

  cla_slice #(.CHUNK_W(CHUNK_W)) u_slice (
    .x  (x_s),
    .y  (y_s),
    .ci (carry_r),
    .s  (slice_sum_s),
    .co (slice_co_s)
  );

  // State register; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode, evaluated on the next state so the outputs leave a flop.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    in_ready_nxt_s  = 1'b1;
      RUN:     in_ready_nxt_s  = 1'b0;
      DONE:    out_valid_nxt_s = 1'b1;
      default: in_ready_nxt_s  = 1'b0;
    endcase
  end

  // Datapath: operand latch on accept, one chunk per RUN cycle, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {TOTAL_W{1'b0}};
      b_r     <= {TOTAL_W{1'b0}};
      sum_r   <= {TOTAL_W{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= a;
            idx_r <= {IDX_W{1'b0}};
`ifdef SUB_EN
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cIn;
`else
            b_r     <= b;
            carry_r <= cIn;
`endif
          end
        end
        RUN: begin
          sum_r[idx_r*CHUNK_W +: CHUNK_W] <= slice_sum_s;
          carry_r <= slice_co_s;
          idx_r   <= idx_r + IDX_W'(1);
          if (last_s) begin
            cout_r <= slice_co_s;
          end
        end
        DONE: begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cOut      = cout_r;

endmodule
